// File: rtl/mem_req_queue_if.sv
// Request/head bus between execute, the memory request queue and the EX/MEM register.
// master = execute/d-cache side driving requests and dc_miss; slave = the queue.
interface mem_req_queue_if #(
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int AL_ID_WIDTH = 6
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_mem_action;
    logic [ADDR_WIDTH-1:0]  in_addr;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [AL_ID_WIDTH-1:0] in_al_id;
    logic                   dc_miss;
    logic                   out_valid;
    logic                   out_mem_action;
    logic [ADDR_WIDTH-1:0]  out_addr;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [AL_ID_WIDTH-1:0] out_al_id;
    logic                   out_bypass_possible;
    logic [AL_ID_WIDTH-1:0] out_bypass_index;
    logic                   out_nop;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   empty;

    modport master (
        output in_valid, in_mem_action, in_addr, in_data, in_al_id, dc_miss,
        input  in_ready, out_valid, out_mem_action, out_addr, out_data, out_al_id,
               out_bypass_possible, out_bypass_index, out_nop, count, full, empty
    );

    modport slave (
        input  in_valid, in_mem_action, in_addr, in_data, in_al_id, dc_miss,
        output in_ready, out_valid, out_mem_action, out_addr, out_data, out_al_id,
               out_bypass_possible, out_bypass_index, out_nop, count, full, empty
    );
endinterface

// File: rtl/mem_req_queue.sv
// In-order show-ahead memory request FIFO feeding the EX/MEM register; optional store-to-load
// forwarding under MEM_REQ_QUEUE_STORE_FWD_EN. Latency: push visible on head one cycle later.
// Backpressure: in_ready=!full; head pops only when !dc_miss; flush squashes everything.
module mem_req_queue #(
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int AL_ID_WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    mem_req_queue_if.slave q
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]          head, tail, cnt;
    logic [IW-1:0]          head_idx, tail_idx;
    logic                   is_full, is_empty, push, pop;
    logic [DATA_WIDTH-1:0]  wr_data;

    logic                   ent_wr   [DEPTH];
    logic [ADDR_WIDTH-1:0]  ent_addr [DEPTH];
    logic [DATA_WIDTH-1:0]  ent_data [DEPTH];
    logic [AL_ID_WIDTH-1:0] ent_id   [DEPTH];

    assign head_idx = head[IW-1:0];
    assign tail_idx = tail[IW-1:0];
    assign cnt      = tail - head;
    assign is_empty = (head == tail);
    assign is_full  = (head_idx == tail_idx) && (head[IW] != tail[IW]);
    assign push     = q.in_valid && !is_full && !flush;
    assign pop      = !is_empty && !q.dc_miss && !flush;

    assign q.in_ready       = !is_full;
    assign q.out_valid      = !is_empty;
    assign q.out_nop        = is_empty;
    assign q.empty          = is_empty;
    assign q.full           = is_full;
    assign q.count          = cnt;
    assign q.out_mem_action = !is_empty && ent_wr[head_idx];
    assign q.out_addr       = is_empty ? '0 : ent_addr[head_idx];
    assign q.out_data       = is_empty ? '0 : ent_data[head_idx];
    assign q.out_al_id      = is_empty ? '0 : ent_id[head_idx];

`ifdef MEM_REQ_QUEUE_STORE_FWD_EN
    logic                   ent_bp     [DEPTH];
    logic [AL_ID_WIDTH-1:0] ent_bp_idx [DEPTH];
    logic [IW-1:0]          slot       [DEPTH];
    logic                   wr_bp;
    logic [AL_ID_WIDTH-1:0] wr_bp_idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) slot[i] = head_idx + IW'(i);
    end

    // Walk oldest to youngest so the last hit is the store closest to tail.
    always_comb begin
        wr_bp     = 1'b0;
        wr_bp_idx = '0;
        wr_data   = q.in_data;
        if (!q.in_mem_action) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((PW'(i) < cnt) && ent_wr[slot[i]] &&
                    (ent_addr[slot[i]][ADDR_WIDTH-1:2] == q.in_addr[ADDR_WIDTH-1:2])) begin
                    wr_bp     = 1'b1;
                    wr_data   = ent_data[slot[i]];
                    wr_bp_idx = ent_id[slot[i]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_bp[i]     <= 1'b0;
                ent_bp_idx[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_bp[i] <= 1'b0;
        end else if (push) begin
            ent_bp[tail_idx]     <= wr_bp;
            ent_bp_idx[tail_idx] <= wr_bp_idx;
        end
    end

    assign q.out_bypass_possible = !is_empty && ent_bp[head_idx];
    assign q.out_bypass_index    = is_empty ? '0 : ent_bp_idx[head_idx];
`else
    assign wr_data               = q.in_data;
    assign q.out_bypass_possible = 1'b0;
    assign q.out_bypass_index    = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_wr[i]   <= 1'b0;
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_id[i]   <= '0;
            end
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                ent_wr[tail_idx]   <= q.in_mem_action;
                ent_addr[tail_idx] <= q.in_addr;
                ent_data[tail_idx] <= wr_data;
                ent_id[tail_idx]   <= q.in_al_id;
                tail               <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
        end
    end
endmodule

// File: doc/mem_req_queue.md
Name: mem_req_queue

Overview:
- In-order memory-request FIFO directly upstream of the execute-to-memory pipeline register; it feeds that register's d-cache input and d-cache control fields.
- Execute pushes address-resolved loads and stores. The queue presents the oldest entry (show-ahead) and pops it only when the d-cache is not missing, so execute is decoupled from d-cache miss stalls.
- Branch-recovery flush empties it.

Parameters:
- DEPTH, 8, number of entries; power of 2, >= 2
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, store/forward data width
- AL_ID_WIDTH, 6, active-list id width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of all entries
- in_valid  in  1  request present
- in_ready  out  1  queue can accept (= !full)
- in_mem_action  in  1  0=READ, 1=WRITE
- in_addr  in  ADDR_WIDTH  byte address
- in_data  in  DATA_WIDTH  store data (ignored for loads)
- in_al_id  in  AL_ID_WIDTH  active-list id
- dc_miss  in  1  d-cache miss; head must hold
- out_valid  out  1  head entry valid (= !empty)
- out_mem_action  out  1  head action
- out_addr  out  ADDR_WIDTH  head address
- out_data  out  DATA_WIDTH  head data
- out_al_id  out  AL_ID_WIDTH  head active-list id
- out_bypass_possible  out  1  head load has forwarded store data
- out_bypass_index  out  AL_ID_WIDTH  al_id of the forwarding store
- out_nop  out  1  = empty
- count  out  $clog2(DEPTH)+1  occupancy
- full  out  1  count==DEPTH
- empty  out  1  count==0

Behaviour:
- Storage and pointers:
  - Circular buffer; head/tail pointers are $clog2(DEPTH)+1 bits, with an extra wrap bit.
  - full = index bits equal and wrap bits differ; empty = pointers equal.
- Reset (async, rst_n=0):
  - head=tail=0; every entry's fields cleared to 0.
  - Resulting outputs: out_valid=0, out_nop=1, empty=1, full=0, count=0, in_ready=1, all out_* data fields 0.
- Enqueue: when in_valid && in_ready && !flush, write at tail and increment tail on the rising edge.
- Dequeue: when out_valid && !dc_miss && !flush, increment head on the rising edge.
  - Downstream register captures the head in the same cycle, since it loads when !dc_miss.
- Head outputs are combinational from the head entry. They are zero when empty, except out_nop=1.
- Latency: an entry pushed into an empty queue appears on out_* in the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop: both happen and count is unchanged. When full, in_ready=0, so no push that cycle even if a pop occurs.
- dc_miss=1: head holds. Pushes continue until full.
- Flush:
  - Next edge sets head=tail=0 and clears every entry's bypass flag.
  - A push or pop in the flush cycle is discarded; flush has priority.
  - Entry data need not be cleared.
- Wrap-around: pointer index wraps modulo DEPTH and the wrap bit toggles. count = tail - head, computed in pointer width.
- Reset mid-operation: immediate return to the reset state regardless of dc_miss or flush.

Optional Feature:
- Macro: MEM_REQ_QUEUE_STORE_FWD_EN.
- Defined:
  - On enqueue of a READ, compare in_addr[ADDR_WIDTH-1:2] against all resident WRITE entries, including the head even if it pops this cycle.
  - On a match, select the youngest matching store (closest to tail).
  - The load entry then stores bypass=1, data=store's data, bypass_index=store's al_id.
  - Stores always record bypass=0.
  - Word granularity only.
- Undefined: no comparators; out_bypass_possible=0 and out_bypass_index=0 constantly; load data field stores in_data.

Test Plan:
- Reset, then push WRITE addr 0x100 data 0xAA al_id 3 -> next cycle out_valid=1, out_addr=0x100, out_data=0xAA, out_al_id=3, count=1, out_nop=0.
- Hold dc_miss=1 and push 8 entries -> full=1, in_ready=0, head unchanged. Drop dc_miss -> one pop per cycle, in push order, count reaches 0, empty=1.
- 20 push/pop pairs with DEPTH=8 -> FIFO order preserved across wrap, count stays constant.
- Assert flush while count=5 and in_valid=1 -> next cycle empty=1, count=0, and the pushed entry is absent.
- With MEM_REQ_QUEUE_STORE_FWD_EN:
  - Push WRITE 0x200/0x11 al 4, then WRITE 0x200/0x22 al 5, then READ 0x203 al 6 -> load reaches head with out_bypass_possible=1, out_data=0x22, out_bypass_index=5.
  - READ 0x204 -> out_bypass_possible=0.
- Assert rst_n low asynchronously mid-burst with dc_miss=1 -> outputs go to reset values before the next clock edge.
